dmem_lsu: RTL

Load/store sequencer between the datapath's memory-stage request and the 32-byte data memory. Accepts one request at a time over a valid/ready handshake. Executes single-byte LOAD/STORE and multi-byte COPY/FILL by driving the data memory's address, read-enable, write-data and write-enable ports. Returns a one-cycle response pulse with read data and a range-error flag.

---
 rtl/dmem_lsu_if.sv | 33 +++
 rtl/dmem_lsu.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - request/response handshake and data-memory port bundle for dmem_lsu
interface dmem_lsu_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_src;
  logic [5:0]        req_len;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] memA;
  logic              memRE;
  logic [DATA_W-1:0] memRD;
  logic [DATA_W-1:0] memWD;
  logic              memWE;

  // Requester side: issues requests, owns the memory and returns read data.
  modport master (
    output req_valid, req_op, req_addr, req_src, req_len, req_wdata, memRD,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, memA, memRE, memWD, memWE
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_op, req_addr, req_src, req_len, req_wdata, memRD,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, memA, memRE, memWD, memWE
  );
endinterface

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store/copy/fill sequencer in front of the data memory
module dmem_lsu #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 32
) (
  input logic       clk,
  input logic       clr,
  dmem_lsu_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, STORE, CP_RD, CP_WR, FILL} state_t;

  state_t            state, stateNext;
  logic [ADDR_W-1:0] dstPtr, srcPtr;
  logic [5:0]        cnt;
  logic [DATA_W-1:0] fillData, byteBuf;
  logic              rspValid, rspErr;
  logic [DATA_W-1:0] rspRdata;
  logic [ADDR_W-1:0] memA;
  logic [DATA_W-1:0] memWD;
  logic              memRE, memWE;

  logic              accept, reqErr, lenZero;
  logic [ADDR_W:0]   dstEnd, srcEnd, depth;

  assign accept  = (state == IDLE) && bus.req_valid;
  assign depth   = (ADDR_W+1)'(MEM_DEPTH);
  // One extra bit so base+len never wraps back into range.
  assign dstEnd  = {1'b0, bus.req_addr} + (ADDR_W+1)'(bus.req_len);
  assign srcEnd  = {1'b0, bus.req_src}  + (ADDR_W+1)'(bus.req_len);
  assign lenZero = bus.req_op[1] && (bus.req_len == 6'd0);

  // Range check of the incoming request, evaluated at acceptance.
  always_comb begin
    reqErr = 1'b0;
    case (bus.req_op)
      2'b00, 2'b01: reqErr = ({1'b0, bus.req_addr} >= depth);
      2'b10:        reqErr = (srcEnd > depth) || (dstEnd > depth);
      default:      reqErr = (dstEnd > depth);
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state decode; errored and zero-length requests never leave IDLE.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept && !reqErr && !lenZero) begin
          case (bus.req_op)
            2'b00:   stateNext = LOAD;
            2'b01:   stateNext = STORE;
            2'b10:   stateNext = CP_RD;
            default: stateNext = FILL;
          endcase
        end
      end
      LOAD, STORE: stateNext = IDLE;
      CP_RD:       stateNext = CP_WR;
      CP_WR:       stateNext = (cnt == 6'd1) ? IDLE : CP_RD;
      FILL:        stateNext = (cnt == 6'd1) ? IDLE : FILL;
      default:     stateNext = IDLE;
    endcase
  end

  // Request latching, pointer/counter stepping and response generation.
  always_ff @(posedge clk) begin
    if (clr) begin
      dstPtr   <= '0;
      srcPtr   <= '0;
      cnt      <= '0;
      fillData <= '0;
      byteBuf  <= '0;
      rspValid <= 1'b0;
      rspErr   <= 1'b0;
      rspRdata <= '0;
    end else begin
      rspValid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dstPtr   <= bus.req_addr;
            srcPtr   <= bus.req_src;
            cnt      <= bus.req_len;
            fillData <= bus.req_wdata;
            if (reqErr || lenZero) begin
              rspValid <= 1'b1;
              rspErr   <= reqErr;
              rspRdata <= '0;
            end
          end
        end
        LOAD: begin
          rspValid <= 1'b1;
          rspErr   <= 1'b0;
          rspRdata <= bus.memRD;
        end
        STORE: begin
          rspValid <= 1'b1;
          rspErr   <= 1'b0;
          rspRdata <= '0;
        end
        CP_RD: byteBuf <= bus.memRD;
        CP_WR: begin
          dstPtr <= dstPtr + 1'b1;
          srcPtr <= srcPtr + 1'b1;
          cnt    <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            rspValid <= 1'b1;
            rspErr   <= 1'b0;
            rspRdata <= byteBuf;
          end
        end
        FILL: begin
          dstPtr <= dstPtr + 1'b1;
          cnt    <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            rspValid <= 1'b1;
            rspErr   <= 1'b0;
            rspRdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory port decode; enables are gated by clr so an abort issues no access.
  always_comb begin
    memA  = '0;
    memWD = '0;
    memRE = 1'b0;
    memWE = 1'b0;
    case (state)
      LOAD:  begin memA = dstPtr; memRE = 1'b1; end
      STORE: begin memA = dstPtr; memWD = fillData; memWE = 1'b1; end
      CP_RD: begin memA = srcPtr; memRE = 1'b1; end
      CP_WR: begin memA = dstPtr; memWD = byteBuf;  memWE = 1'b1; end
      FILL:  begin memA = dstPtr; memWD = fillData; memWE = 1'b1; end
      default: ;
    endcase
    if (clr) begin
      memRE = 1'b0;
      memWE = 1'b0;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rspValid;
  assign bus.rsp_rdata = rspRdata;
  assign bus.rsp_err   = rspErr;
  assign bus.memA      = memA;
  assign bus.memWD     = memWD;
  assign bus.memRE     = memRE;
  assign bus.memWE     = memWE;
endmodule
